// File: rtl/weighted_grade_calc.sv
`default_nettype none
// ============================================================================
// Module      : weighted_grade_calc
// Description : Gradebook engine. Accumulates saturating per-category scores
//               and computes a weighted course percentage (floor) plus a
//               one-hot letter grade using a one-category-per-cycle MAC.
// Revision    : 1.0 - initial release
// ============================================================================
module weighted_grade_calc #(
    parameter int                     NUM_CAT   = 4,
    parameter int                     SCORE_W   = 7,
    parameter int                     MAX_SCORE = 100,
    parameter logic [NUM_CAT*7-1:0]   WEIGHTS   = {NUM_CAT{7'd25}},
    parameter int                     THR_A     = 90,
    parameter int                     THR_B     = 80,
    parameter int                     THR_C     = 70,
    parameter int                     THR_D     = 60
) (
    input  logic                         clock,
    input  logic                         reset_L,
    input  logic [SCORE_W-1:0]           score,
    input  logic [$clog2(NUM_CAT)-1:0]   score_type,
    input  logic                         start,
    input  logic                         grade_it,
    output logic                         busy,
    output logic                         done,
    output logic [6:0]                   total,
    output logic                         grade_A,
    output logic                         grade_B,
    output logic                         grade_C,
    output logic                         grade_D,
    output logic                         grade_R
);

    localparam int c_idx_w  = $clog2(NUM_CAT);
    localparam int c_sum_w  = $clog2(MAX_SCORE * 100 + 1);
    // Product of a score and a 7-bit weight; the running sum never exceeds it
    localparam int c_wide_w = SCORE_W + 7;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_CAT - 1);
    localparam logic [SCORE_W:0]   c_max_ext  = (SCORE_W + 1)'(MAX_SCORE);

    function automatic int weight_sum();
        int s;
        s = 0;
        for (int i = 0; i < NUM_CAT; i++) begin
            s += int'(WEIGHTS[i*7 +: 7]);
        end
        return s;
    endfunction

    if (weight_sum() != 100) begin : g_weight_chk
        $error("weighted_grade_calc: WEIGHTS must sum to 100");
    end

    if (MAX_SCORE >= (1 << SCORE_W)) begin : g_max_chk
        $error("weighted_grade_calc: MAX_SCORE must fit in SCORE_W bits");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SCORE_W-1:0]   acc_q [NUM_CAT];
    logic [SCORE_W-1:0]   acc_d [NUM_CAT];
    logic [c_idx_w-1:0]   idx_q, idx_d;
    logic [c_sum_w-1:0]   sum_q, sum_d;
    logic [6:0]           total_q, total_d;
    logic [4:0]           grade_q, grade_d;   // {A,B,C,D,R}

    logic                 w_accept;
    logic                 w_type_ok;
    logic [SCORE_W-1:0]   w_base;
    logic [SCORE_W:0]     w_add;
    logic [6:0]           w_weight;
    logic [c_wide_w-1:0]  w_prod;
    logic [c_wide_w-1:0]  w_mac;
    logic [6:0]           w_total_new;
    logic [4:0]           w_grade_new;

    // Datapath: command acceptance, saturating add and one MAC step
    always_comb begin
        w_accept    = (state_q != CALC) && (start || grade_it);
        w_type_ok   = 32'(score_type) < NUM_CAT;
        w_base      = start ? '0 : acc_q[score_type];
        w_add       = {1'b0, w_base} + {1'b0, score};
        w_weight    = WEIGHTS[32'(idx_q)*7 +: 7];
        w_prod      = c_wide_w'(acc_q[idx_q]) * c_wide_w'(w_weight);
        w_mac       = c_wide_w'(sum_q) + w_prod;
        w_total_new = 7'(w_mac / c_wide_w'(100));
        if (32'(w_total_new) >= THR_A)      w_grade_new = 5'b10000;
        else if (32'(w_total_new) >= THR_B) w_grade_new = 5'b01000;
        else if (32'(w_total_new) >= THR_C) w_grade_new = 5'b00100;
        else if (32'(w_total_new) >= THR_D) w_grade_new = 5'b00010;
        else                                w_grade_new = 5'b00001;
    end

    // Next-state: accumulator update on accept, sequencing through categories in CALC
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        total_d = total_q;
        grade_d = grade_q;
        acc_d   = acc_q;
        case (state_q)
            CALC: begin
                if (idx_q == c_last_idx) begin
                    total_d = w_total_new;
                    grade_d = w_grade_new;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = DONE;
                end else begin
                    sum_d = c_sum_w'(w_mac);
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                // IDLE and DONE both accept commands; DONE falls back to IDLE otherwise
                if (w_accept) begin
                    if (start) begin
                        for (int i = 0; i < NUM_CAT; i++) begin
                            acc_d[i] = '0;
                        end
                    end
                    if (grade_it && w_type_ok) begin
                        acc_d[score_type] = (w_add > c_max_ext) ? SCORE_W'(MAX_SCORE)
                                                                 : w_add[SCORE_W-1:0];
                    end
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sum_q   <= '0;
            total_q <= '0;
            grade_q <= 5'b00001;
            for (int i = 0; i < NUM_CAT; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            total_q <= total_d;
            grade_q <= grade_d;
            acc_q   <= acc_d;
        end
    end

    assign busy    = (state_q == CALC);
    assign done    = (state_q == DONE);
    assign total   = total_q;
    assign grade_A = grade_q[4];
    assign grade_B = grade_q[3];
    assign grade_C = grade_q[2];
    assign grade_D = grade_q[1];
    assign grade_R = grade_q[0];

endmodule
`default_nettype wire

// File: tb/tb_weighted_grade_calc.sv
`default_nettype none
// ============================================================================
// Module      : tb_weighted_grade_calc
// Description : Scoreboard bench for weighted_grade_calc. Instance 0 uses the
//               default four equal weights, instance 1 uses three categories
//               weighted 50/30/20.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weighted_grade_calc;

    localparam int N0 = 4;
    localparam int N1 = 3;
    localparam logic [4:0] G_A = 5'b10000, G_B = 5'b01000, G_C = 5'b00100,
                           G_D = 5'b00010, G_R = 5'b00001;

    logic clock = 1'b0;
    logic rst_l = 1'b0;
    always #5 clock = ~clock;

    logic [6:0] score0 = '0, score1 = '0;
    logic [1:0] type0 = '0, type1 = '0;
    logic       start0 = 1'b0, gi0 = 1'b0, start1 = 1'b0, gi1 = 1'b0;
    logic       busy0, done0, a0, b0, c0, d0, r0;
    logic       busy1, done1, a1, b1, c1, d1, r1;
    logic [6:0] total0, total1;

    weighted_grade_calc u_dut0 (
        .clock(clock), .reset_L(rst_l), .score(score0), .score_type(type0),
        .start(start0), .grade_it(gi0), .busy(busy0), .done(done0), .total(total0),
        .grade_A(a0), .grade_B(b0), .grade_C(c0), .grade_D(d0), .grade_R(r0)
    );

    weighted_grade_calc #(
        .NUM_CAT(3), .WEIGHTS({7'd20, 7'd30, 7'd50})
    ) u_dut1 (
        .clock(clock), .reset_L(rst_l), .score(score1), .score_type(type1),
        .start(start1), .grade_it(gi1), .busy(busy1), .done(done1), .total(total1),
        .grade_A(a1), .grade_B(b1), .grade_C(c1), .grade_D(d1), .grade_R(r1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: per-instance category totals and weights
    int m_acc [2][8];
    int m_w   [2][8];
    int m_n   [2];
    int q0 [$];
    int q1 [$];

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    function automatic logic [4:0] grade_of(input int t);
        if (t >= 90) return G_A;
        if (t >= 80) return G_B;
        if (t >= 70) return G_C;
        if (t >= 60) return G_D;
        return G_R;
    endfunction

    function automatic int exp_total(input int d);
        int s = 0;
        for (int i = 0; i < m_n[d]; i++) s += m_acc[d][i] * m_w[d][i];
        return s / 100;
    endfunction

    function automatic logic get_busy(input int d);
        return (d == 0) ? busy0 : busy1;
    endfunction
    function automatic logic get_done(input int d);
        return (d == 0) ? done0 : done1;
    endfunction
    function automatic int get_total(input int d);
        return (d == 0) ? int'(total0) : int'(total1);
    endfunction
    function automatic int get_grade(input int d);
        return (d == 0) ? int'({a0, b0, c0, d0, r0}) : int'({a1, b1, c1, d1, r1});
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++) m_acc[d][i] = 0;
    endtask

    task automatic model_cmd(input int d, input bit st, input bit gi, input int typ, input int sc);
        int v;
        if (st) for (int i = 0; i < m_n[d]; i++) m_acc[d][i] = 0;
        if (gi && typ < m_n[d]) begin
            v = m_acc[d][typ] + sc;
            m_acc[d][typ] = (v > 100) ? 100 : v;
        end
        if (d == 0) q0.push_back(exp_total(0));
        else        q1.push_back(exp_total(1));
    endtask

    task automatic drive(input int d, input bit st, input bit gi, input int typ, input int sc);
        if (d == 0) begin start0 = st; gi0 = gi; type0 = 2'(typ); score0 = 7'(sc); end
        else        begin start1 = st; gi1 = gi; type1 = 2'(typ); score1 = 7'(sc); end
    endtask

    // Issue one command; b2b waits for the done cycle so it is accepted from DONE
    task automatic do_cmd(input int d, input bit st, input bit gi, input int typ,
                          input int sc, input bit b2b);
        int n = 0;
        while (n < 100) begin
            @(negedge clock);
            if (b2b ? get_done(d) : !get_busy(d)) break;
            n++;
        end
        if (n == 100) begin
            chk("cmd_wait_timeout", n, 0);
            return;
        end
        drive(d, st, gi, typ, sc);
        model_cmd(d, st, gi, typ, sc);
        @(negedge clock);
        drive(d, 1'b0, 1'b0, 0, 0);
        chk("busy_after_accept", int'(get_busy(d)), 1);
    endtask

    // Pulse grade_it while the engine is calculating; it must be ignored
    task automatic drop_cmd(input int d, input int typ, input int sc);
        chk("drop_while_busy", int'(get_busy(d)), 1);
        drive(d, 1'b0, 1'b1, typ, sc);
        @(negedge clock);
        drive(d, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while (n < 100) begin
            @(negedge clock);
            if (!get_busy(d) && !get_done(d)) break;
            n++;
        end
        if (n == 100) chk("idle_wait_timeout", n, 0);
    endtask

    task automatic check_now(input int d, input string name, input int t, input logic [4:0] g);
        wait_idle(d);
        chk({name, "_total"}, get_total(d), t);
        chk({name, "_grade"}, get_grade(d), int'(g));
    endtask

    logic rst_edge = 1'b1;
    always @(posedge clock) rst_edge <= !rst_l;

    int cnt0 = 0, last0 = 0, e0;
    // Monitor for instance 0: scoreboard pop on done, hold and busy-length checks
    always @(negedge clock) begin
        chk("onehot0", $countones({a0, b0, c0, d0, r0}), 1);
        if (rst_edge) begin
            cnt0 = 0; last0 = total0;
        end else if (done0) begin
            chk("busy_len0", cnt0, N0);
            cnt0 = 0;
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done0: got total=%0d, expected no result", total0);
            end else begin
                e0 = q0.pop_front();
                chk("total0", int'(total0), e0);
                chk("grade0", int'({a0, b0, c0, d0, r0}), int'(grade_of(e0)));
            end
            last0 = total0;
        end else begin
            if (busy0) cnt0++;
            chk("hold0", int'(total0), last0);
        end
    end

    int cnt1 = 0, last1 = 0, e1;
    // Monitor for instance 1
    always @(negedge clock) begin
        chk("onehot1", $countones({a1, b1, c1, d1, r1}), 1);
        if (rst_edge) begin
            cnt1 = 0; last1 = total1;
        end else if (done1) begin
            chk("busy_len1", cnt1, N1);
            cnt1 = 0;
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done1: got total=%0d, expected no result", total1);
            end else begin
                e1 = q1.pop_front();
                chk("total1", int'(total1), e1);
                chk("grade1", int'({a1, b1, c1, d1, r1}), int'(grade_of(e1)));
            end
            last1 = total1;
        end else begin
            if (busy1) cnt1++;
            chk("hold1", int'(total1), last1);
        end
    end

    initial begin
        bit st, gi, b2b;
        m_n[0] = N0; m_n[1] = N1;
        for (int i = 0; i < 8; i++) begin m_w[0][i] = 0; m_w[1][i] = 0; end
        for (int i = 0; i < N0; i++) m_w[0][i] = 25;
        m_w[1][0] = 50; m_w[1][1] = 30; m_w[1][2] = 20;
        model_reset();

        // Reset and quiet idle
        repeat (3) @(negedge clock);
        rst_l = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_total", int'(total0), 0);
        chk("rst_grade", get_grade(0), int'(G_R));

        // Basic accumulate
        do_cmd(0, 1, 1, 0, 50, 0);
        check_now(0, "hw50", 12, G_R);
        do_cmd(0, 0, 1, 0, 38, 0);
        check_now(0, "hw88", 22, G_R);

        // Threshold boundaries
        do_cmd(0, 1, 1, 0, 100, 0);
        do_cmd(0, 0, 1, 1, 100, 0);
        do_cmd(0, 0, 1, 2, 40, 0);
        do_cmd(0, 0, 1, 3, 0, 0);
        check_now(0, "d_edge", 60, G_D);
        do_cmd(0, 0, 1, 3, 3, 0);
        check_now(0, "d_cp3", 60, G_D);
        do_cmd(0, 0, 1, 2, 40, 0);
        do_cmd(0, 0, 1, 3, 77, 0);
        check_now(0, "a_edge", 90, G_A);

        // Saturation, dropped command, back-to-back, start alone
        do_cmd(0, 0, 1, 2, 50, 0);
        do_cmd(0, 0, 1, 2, 50, 0);
        check_now(0, "sat", 95, G_A);
        do_cmd(0, 0, 1, 3, 0, 0);
        drop_cmd(0, 3, 20);
        check_now(0, "dropped", 95, G_A);
        do_cmd(0, 0, 1, 3, 10, 0);
        do_cmd(0, 0, 1, 3, 5, 1);
        check_now(0, "b2b", 98, G_A);
        do_cmd(0, 1, 0, 0, 0, 0);
        check_now(0, "start_only", 0, G_R);

        // Randomized traffic on instance 0
        for (int k = 0; k < 60; k++) begin
            st  = ($urandom_range(0, 7) == 0);
            gi  = ($urandom_range(0, 3) != 0);
            if (!st && !gi) gi = 1'b1;
            b2b = get_busy(0) && ($urandom_range(0, 3) == 0);
            do_cmd(0, st, gi, $urandom_range(0, 3), $urandom_range(0, 127), b2b);
            if ($urandom_range(0, 4) == 0) drop_cmd(0, $urandom_range(0, 3), $urandom_range(0, 127));
        end
        wait_idle(0);

        // Three-category instance
        do_cmd(1, 1, 1, 0, 90, 0);
        do_cmd(1, 0, 1, 1, 80, 0);
        do_cmd(1, 0, 1, 2, 70, 0);
        check_now(1, "v3_b", 83, G_B);
        do_cmd(1, 0, 1, 3, 50, 0);
        check_now(1, "v3_oor", 83, G_B);
        for (int k = 0; k < 30; k++) begin
            st  = ($urandom_range(0, 7) == 0);
            gi  = ($urandom_range(0, 3) != 0);
            if (!st && !gi) gi = 1'b1;
            b2b = get_busy(1) && ($urandom_range(0, 3) == 0);
            do_cmd(1, st, gi, $urandom_range(0, 3), $urandom_range(0, 127), b2b);
            if ($urandom_range(0, 4) == 0) drop_cmd(1, $urandom_range(0, 3), $urandom_range(0, 127));
        end
        wait_idle(1);

        // Reset in the middle of a calculation (at the idx=2 edge)
        do_cmd(0, 1, 1, 1, 60, 0);
        check_now(0, "pre_rst", 15, G_R);
        do_cmd(0, 0, 1, 2, 10, 0);
        @(negedge clock);
        @(negedge clock);
        rst_l = 1'b0;
        q0.delete();
        model_reset();
        @(negedge clock);
        chk("midrst_busy", int'(busy0), 0);
        chk("midrst_done", int'(done0), 0);
        chk("midrst_total", int'(total0), 0);
        chk("midrst_grade", get_grade(0), int'(G_R));
        rst_l = 1'b1;
        do_cmd(0, 0, 1, 0, 50, 0);
        check_now(0, "post_rst", 12, G_R);

        repeat (3) @(negedge clock);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/weighted_grade_calc.md
Name: weighted_grade_calc

Overview:
Parametrised gradebook engine that accumulates per-category scores and computes a weighted course percentage and letter grade. It generalises the fixed four-category, equal-weight grader:
- category count, score width and per-category weights are parameters;
- per-category totals saturate;
- the weighted total is computed by a multi-cycle multiply-accumulate sequencer with a busy/done handshake.

It sits beside the score-entry front end and feeds the grade display.

Parameters:
NUM_CAT, 4, number of score categories (2..8)
SCORE_W, 7, width of score input and each category accumulator
MAX_SCORE, 100, saturation ceiling per category (must be < 2**SCORE_W)
WEIGHTS, {4{7'd25}}, packed NUM_CAT*7-bit vector; category i weight (percent) at bits [7i+6:7i]; weights sum to 100, checked by elaboration assertion
THR_A/THR_B/THR_C/THR_D, 90/80/70/60, minimum total (inclusive) for each letter

Ports:
clock  in  1  system clock, all state on rising edge
reset_L  in  1  synchronous, active-low reset
score  in  SCORE_W  score to add
score_type  in  $clog2(NUM_CAT)  category index
start  in  1  clear all categories (new student)
grade_it  in  1  add score to category score_type
busy  out  1  calculation in progress; commands ignored
done  out  1  one-cycle pulse: total/grade just updated
total  out  7  weighted percentage, floor, 0..100
grade_A, grade_B, grade_C, grade_D, grade_R  out  1 each  one-hot letter grade

Behaviour:
- Reset (reset_L=0 at an edge), from any state including mid-CALC:
  - all accumulators 0, total=0;
  - grade_R=1, other grade outputs 0;
  - busy=0, done=0, state IDLE, sequencer index 0.
- Command = start|grade_it. It is accepted only at an edge where the state is IDLE or DONE. In CALC, commands are dropped silently with no state change.
- On accept:
  - base = 0 if start else acc[score_type];
  - if start, every acc is cleared;
  - if grade_it and score_type < NUM_CAT, acc[score_type] = min(base+score, MAX_SCORE). Compute the sum at SCORE_W+1 bits before clamping.
  - An out-of-range score_type adds nothing; a start in the same command still clears.
  - start without grade_it clears all categories and still triggers a recalc.
- FSM:
  - IDLE --accept--> CALC, idx=0, sum=0.
  - CALC, one category per cycle: sum += acc[idx]*W[idx]; idx++.
  - The CALC cycle with idx=NUM_CAT-1 registers total = (sum + acc[idx]*W[idx]) / 100, registers the grade, and goes to DONE.
  - DONE: done=1 for exactly one cycle. Next state is CALC if a command is accepted in that cycle, else IDLE.
- busy=1 exactly while in CALC: NUM_CAT cycles after the accept edge. done is high in the cycle after the NUM_CAT-th CALC edge.
- Arithmetic:
  - sum width ceil(log2(MAX_SCORE*100+1)) bits (14 for defaults);
  - division by constant 100, floor (no rounding);
  - total width 7 bits.
- Grade decode:
  - total >= THR_A -> A; >= THR_B -> B; >= THR_C -> C; >= THR_D -> D; else R.
  - Exactly one grade output high at all times.
- total and grade outputs hold their last value between recalcs. They do not change during CALC.
- Accumulators are never read or written outside the accept edge and the CALC sequencing. Inputs are sampled only at the accept edge.

Test Plan:
1. Hold reset_L=0 two edges, release -> busy=0, done=0, total=0, grade_R=1; IDLE persists with no commands.
2. start=1, grade_it=1, HW(0)=50 -> busy high 4 cycles; done pulses once; total=12 (floor 12.5), grade_R. Then HW+38 -> total=22, R.
3. Boundary, default weights:
   - HW 100, LAB 100, EXAM 40, CP 0 -> total=60, grade_D exactly; then CP+3 -> 60, D.
   - Then EXAM+40 and CP+77 (EXAM 80, CP 80) -> total=90, grade_A.
4. Saturation and ignore rules:
   - EXAM=100 then EXAM+50 -> acc stays 100, total unchanged.
   - grade_it asserted while busy=1 -> dropped; total after done matches no-add value.
   - start alone -> all acc=0, total=0, R after done.
5. Parameter variant NUM_CAT=3, WEIGHTS 50/30/20:
   - scores 90, 80, 70 -> total=83, grade_B; busy lasts 3 cycles;
   - score_type=3 (out of range) adds nothing.
6. Back-to-back and reset:
   - command accepted in the DONE cycle -> CALC directly, no IDLE cycle.
   - reset_L=0 during CALC idx=2 -> next cycle IDLE, total=0, grade_R, acc all 0.
